// File: rtl/aes_key_expansion_128_if.sv
// Key-schedule bus: the key loader drives start/short_key, the expander returns
// the current round key and a completion flag.
interface aes_key_expansion_128_if;
  logic         start;
  logic [127:0] short_key;
  logic [127:0] subkey;
  logic         rdy;

  modport master (output start, output short_key, input subkey, input rdy);
  modport slave  (input start, input short_key, output subkey, output rdy);
endinterface

// File: rtl/aes_key_expansion_128.sv
// Iterative AES-128 key schedule: emits round keys K0..K10, one per clock after start,
// holding only the current round key.
module aes_key_expansion_128 (
  input  logic                     clk,
  input  logic                     reset,
  aes_key_expansion_128_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // FIPS-197 S-box, entry 0 is the leftmost byte.
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  state_e       state_q, state_d;
  logic [3:0]   rnd_q, rnd_d;
  logic [127:0] subkey_q, subkey_d;

  logic [3:0]   rnd_next;
  logic [7:0]   rcon;
  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  rot_w3, sub_w3, t_word;
  logic [31:0]  n0, n1, n2, n3;
  logic [127:0] next_key;

  assign rnd_next = rnd_q + 4'd1;

  always_comb begin
    rcon = 8'h00;
    case (rnd_next)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  // One round of the schedule: four S-box lookups feeding a ripple XOR chain.
  assign {w0, w1, w2, w3} = subkey_q;
  assign rot_w3 = {w3[23:0], w3[31:24]};
  assign sub_w3 = {SBOX[rot_w3[31:24]], SBOX[rot_w3[23:16]],
                   SBOX[rot_w3[15:8]],  SBOX[rot_w3[7:0]]};
  assign t_word = sub_w3 ^ {rcon, 24'h0};
  assign n0 = w0 ^ t_word;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;
  assign next_key = {n0, n1, n2, n3};

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    state_d  = state_q;
    rnd_d    = rnd_q;
    subkey_d = subkey_q;
    if (bus.start) begin
      // A new start wins over advancement and aborts any expansion in flight.
      state_d  = ST_RUN;
      rnd_d    = 4'd0;
      subkey_d = bus.short_key;
    end else if (state_q == ST_RUN) begin
      subkey_d = next_key;
      rnd_d    = rnd_next;
      if (rnd_next == 4'd10) state_d = ST_DONE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!reset) begin
      state_q  <= ST_IDLE;
      rnd_q    <= 4'd0;
      subkey_q <= 128'h0;
    end else begin
      state_q  <= state_d;
      rnd_q    <= rnd_d;
      subkey_q <= subkey_d;
    end
  end

  assign bus.subkey = subkey_q;
  assign bus.rdy    = (state_q == ST_DONE);

endmodule

// File: tb/tb_aes_key_expansion_128.sv
// Randomized bench for aes_key_expansion_128 against a FIPS-197 word-level key
// schedule model whose S-box is derived from GF(2^8) inversion plus the affine map.
module tb_aes_key_expansion_128;

  logic clk = 1'b0;
  logic reset;

  aes_key_expansion_128_if bus ();

  aes_key_expansion_128 dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0]   sbox_ref [256];
  logic [127:0] exp_rk   [11];
  logic [127:0] a1_rk    [11];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, want);
  endtask

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int s);
    return (v << s) | (v >> (8 - s));
  endfunction

  task automatic build_sbox();
    for (int v = 0; v < 256; v++) begin
      logic [7:0] inv = 8'h00;
      for (int c = 1; c < 256; c++)
        if (v != 0 && gf_mul(8'(v), 8'(c)) == 8'h01) inv = 8'(c);
      sbox_ref[v] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  // FIPS-197 KeyExpansion over the flat word array w[0..43].
  task automatic model_expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] temp;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      temp = w[i-1];
      if (i % 4 == 0) begin
        temp = {temp[23:0], temp[31:24]};
        temp = {sbox_ref[temp[31:24]], sbox_ref[temp[23:16]],
                sbox_ref[temp[15:8]], sbox_ref[temp[7:0]]} ^ {rc, 24'h0};
        rc = xtime(rc);
      end
      w[i] = w[i-4] ^ temp;
    end
    for (int r = 0; r < 11; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Called at a negedge: drive start for 'hold' edges, checking K0 after each.
  task automatic start_key(input string tag, input logic [127:0] key, input int hold);
    bus.start     = 1'b1;
    bus.short_key = key;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check($sformatf("%s K0 hold%0d", tag, h), bus.subkey, exp_rk[0]);
      check($sformatf("%s rdy K0 hold%0d", tag, h), {127'b0, bus.rdy}, 128'd0);
    end
    bus.start = 1'b0;
  endtask

  // Check K1..K<last>, scrambling short_key each cycle since it must be ignored.
  task automatic follow(input string tag, input int last);
    for (int n = 1; n <= last; n++) begin
      bus.short_key = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      check($sformatf("%s K%0d", tag, n), bus.subkey, exp_rk[n]);
      check($sformatf("%s rdy K%0d", tag, n), {127'b0, bus.rdy}, {127'b0, n == 10});
    end
  endtask

  task automatic load_a1();
    for (int r = 0; r < 11; r++) exp_rk[r] = a1_rk[r];
  endtask

  initial begin
    a1_rk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    a1_rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    a1_rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    a1_rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    a1_rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    a1_rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    a1_rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    a1_rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    a1_rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    a1_rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
    a1_rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    reset         = 1'b0;
    bus.start     = 1'b0;
    bus.short_key = 128'h0;
    build_sbox();

    #3;
    check("reset subkey", bus.subkey, 128'h0);
    check("reset rdy", {127'b0, bus.rdy}, 128'd0);
    @(negedge clk);
    reset = 1'b1;

    // FIPS-197 A.1 vector, then hold in DONE.
    load_a1();
    start_key("a1", a1_rk[0], 1);
    follow("a1", 10);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check($sformatf("done hold subkey c%0d", c), bus.subkey, a1_rk[10]);
      check($sformatf("done hold rdy c%0d", c), {127'b0, bus.rdy}, 128'd1);
    end

    // All-zero key, with the published K1/K10 values pinned.
    model_expand(128'h0);
    exp_rk[1]  = 128'h62636363626363636263636362636363;
    exp_rk[10] = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
    start_key("zero", 128'h0, 1);
    follow("zero", 10);

    // Restart mid-run after K3 is visible.
    model_expand(128'h0);
    start_key("restart first", 128'h0, 1);
    follow("restart first", 3);
    start_key("restart", 128'h0, 1);
    follow("restart", 10);

    // Asynchronous reset between edges while running.
    load_a1();
    start_key("areset", a1_rk[0], 1);
    follow("areset", 3);
    #2 reset = 1'b0;
    #1;
    check("areset subkey immediate", bus.subkey, 128'h0);
    check("areset rdy immediate", {127'b0, bus.rdy}, 128'd0);
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("areset idle subkey c%0d", c), bus.subkey, 128'h0);
      check($sformatf("areset idle rdy c%0d", c), {127'b0, bus.rdy}, 128'd0);
    end

    // Start held for three edges.
    load_a1();
    start_key("hold3", a1_rk[0], 3);
    follow("hold3", 10);

    // Random keys against the model.
    for (int k = 0; k < 6; k++) begin
      logic [127:0] key;
      key = {$urandom, $urandom, $urandom, $urandom};
      model_expand(key);
      start_key($sformatf("rand%0d", k), key, 1 + int'($urandom_range(0, 1)));
      follow($sformatf("rand%0d", k), 10);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
